// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit hex 7-segment driver with tear-free double-buffered load.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_display #(
  parameter int N_DIGITS = 8,
  parameter int CLK_DIV  = 100000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [6:0]            out7,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   en_out
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PC_MAX  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [PW-1:0]              pc;
  logic [IW-1:0]              idx;
  logic [N_DIGITS-1:0][3:0]   shadow, disp;
  logic [N_DIGITS-1:0]        shadow_dp, disp_dp;
  logic [N_DIGITS-1:0]        blank;
  logic                       tick, wrap;
  logic [3:0]                 nib;
  logic                       cur_dp, cur_blank;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: dec7 = 7'h40; 4'h1: dec7 = 7'h79; 4'h2: dec7 = 7'h24; 4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19; 4'h5: dec7 = 7'h12; 4'h6: dec7 = 7'h02; 4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00; 4'h9: dec7 = 7'h10; 4'hA: dec7 = 7'h08; 4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46; 4'hD: dec7 = 7'h21; 4'hE: dec7 = 7'h06; default: dec7 = 7'h0E;
    endcase
  endfunction

  assign tick = (pc == PC_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  // A digit is blank when it and everything above it is zero with no dp lit.
  always_comb begin
    blank = '0;
`ifdef SEG7_LZB_EN
    begin
      logic z;
      z = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
        z = z & (disp[k] == 4'd0) & ~disp_dp[k];
        if (k > 0) blank[k] = z;
      end
    end
`endif
  end

  // Explicit mux keeps the select in range for non-power-of-2 digit counts.
  always_comb begin
    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = disp[k];
        cur_dp    = disp_dp[k];
        cur_blank = blank[k];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc         <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      disp       <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      out7       <= 7'h7F;
      dp_out     <= 1'b1;
      en_out     <= '1;
    end else begin
      pc <= tick ? '0 : pc + PW'(1);
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      if (load) begin
        shadow    <= din;
        shadow_dp <= dp_in;
      end
      // disp takes the pre-load shadow even when a load lands on the wrap tick.
      if (wrap && pending) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
      end
      if (load)      pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
      frame_tick <= wrap;
      en_out     <= ~(N_DIGITS'(1) << idx);
      out7       <= cur_blank ? 7'h7F : dec7(nib);
      dp_out     <= cur_blank | ~cur_dp;
    end
  end
endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (8 digits, 4 cycles per digit).
// Loaded frames are queued when driven and become the expected display at each frame start.
module tb_seg7_scan_display;
  localparam int N = 8;
  localparam int D = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         load = 1'b0;
  logic [31:0]  din = '0;
  logic [7:0]   dp_in = '0;
  logic         pending, frame_tick, dp_out;
  logic [6:0]   out7;
  logic [7:0]   en_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] val; logic [7:0] dp; } frame_t;
  frame_t exp_q[$];
  frame_t shown;

  seg7_scan_display #(.N_DIGITS(N), .CLK_DIV(D)) dut (
    .Clk(Clk), .Reset(Reset), .load(load), .din(din), .dp_in(dp_in),
    .pending(pending), .frame_tick(frame_tick), .out7(out7), .dp_out(dp_out), .en_out(en_out)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] dec_ref(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  // {dp_out, out7} expected for digit d of a displayed frame
  function automatic logic [7:0] exp_out(input frame_t f, input int d);
`ifdef SEG7_LZB_EN
    logic z;
    z = 1'b1;
    for (int k = 7; k >= d; k--) if (f.val[4*k +: 4] != 4'd0 || f.dp[k]) z = 1'b0;
    if (d > 0 && z) return 8'hFF;
`endif
    return {~f.dp[d], dec_ref(f.val[4*d +: 4])};
  endfunction

  function automatic int dg(input int c);
    return ((c - 1) / D) % N;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (cyc % (N*D) == 1 && exp_q.size() > 0) shown = exp_q.pop_front();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({out7, dp_out, en_out, pending, frame_tick} !== {7'h7F, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got out7=%h dp=%b en=%h pend=%b ft=%b", out7, dp_out, en_out, pending, frame_tick);
    end
    Reset = 1'b1;
    cyc = 0;
    shown = '{32'h0, 8'h0};
    exp_q.delete();
    step();
    checks++;
    if ({en_out, out7, dp_out} !== {8'hFE, 7'h40, 1'b1}) begin
      errors++;
      $display("FAIL first_after_release got en=%h out7=%h dp=%b exp en=fe out7=40 dp=1", en_out, out7, dp_out);
    end
  endtask

  task automatic test_scan();
    repeat (63) begin
      step();
      checks++;
      if (en_out !== ~(8'h01 << dg(cyc))) begin
        errors++;
        $display("FAIL scan_en cyc=%0d got=%h exp=%h", cyc, en_out, ~(8'h01 << dg(cyc)));
      end
      checks++;
      if (frame_tick !== (cyc % (N*D) == 0)) begin
        errors++;
        $display("FAIL scan_frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, cyc % (N*D) == 0);
      end
    end
  endtask

  task automatic test_load();
    while (cyc < 69) step();
    din = 32'h0123ABCD; dp_in = 8'h01; load = 1'b1;
    exp_q.push_back('{din, dp_in});
    step();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL load_pending got=%b exp=1", pending); end
    while (cyc < 128) begin
      step();
      checks++;
      if ({dp_out, out7} !== exp_out(shown, dg(cyc)) || en_out !== ~(8'h01 << dg(cyc))) begin
        errors++;
        $display("FAIL load_frame cyc=%0d got=%h/%h exp=%h/%h", cyc, {dp_out, out7}, en_out,
                 exp_out(shown, dg(cyc)), ~(8'h01 << dg(cyc)));
      end
      if (cyc == 95 || cyc == 96) begin
        checks++;
        if (pending !== (cyc == 95)) begin
          errors++; $display("FAIL load_pending_wrap cyc=%0d got=%b exp=%b", cyc, pending, cyc == 95);
        end
      end
      if (cyc == 97) begin
        checks++;
        if ({out7, dp_out} !== {7'h21, 1'b0}) begin
          errors++; $display("FAIL load_digit0 got out7=%h dp=%b exp 21/0", out7, dp_out);
        end
      end
      if (cyc == 125) begin
        checks++;
`ifdef SEG7_LZB_EN
        if (out7 !== 7'h7F) begin errors++; $display("FAIL load_digit7 got=%h exp=7f", out7); end
`else
        if (out7 !== 7'h40) begin errors++; $display("FAIL load_digit7 got=%h exp=40", out7); end
`endif
      end
    end
  endtask

  task automatic test_wrap_load();
    while (cyc < 139) step();
    din = 32'h89ABCDEF; dp_in = 8'h10; load = 1'b1;
    exp_q.push_back('{din, dp_in});
    step();
    load = 1'b0;
    while (cyc < 159) step();
    din = 32'h76543210; dp_in = 8'h80; load = 1'b1;
    exp_q.push_back('{din, dp_in});
    step();
    load = 1'b0;
    checks++;
    if ({pending, frame_tick} !== 2'b11) begin
      errors++; $display("FAIL wrap_load_flags got pend=%b ft=%b exp 1/1", pending, frame_tick);
    end
    while (cyc < 224) begin
      step();
      checks++;
      if ({dp_out, out7} !== exp_out(shown, dg(cyc))) begin
        errors++;
        $display("FAIL wrap_load_frame cyc=%0d got=%h exp=%h", cyc, {dp_out, out7}, exp_out(shown, dg(cyc)));
      end
      if (cyc == 161 || cyc == 192) begin
        checks++;
        if (pending !== (cyc == 161)) begin
          errors++; $display("FAIL wrap_load_pending cyc=%0d got=%b exp=%b", cyc, pending, cyc == 161);
        end
      end
      if (cyc == 161 || cyc == 193) begin
        checks++;
        if (out7 !== ((cyc == 161) ? 7'h0E : 7'h40)) begin
          errors++; $display("FAIL wrap_load_digit0 cyc=%0d got=%h exp=%h", cyc, out7, (cyc == 161) ? 7'h0E : 7'h40);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    while (cyc < 229) step();
    din = 32'h11111111; dp_in = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    while (cyc < 239) step();
    din = 32'h22222222; load = 1'b1;
    exp_q.push_back('{din, dp_in});
    step();
    load = 1'b0;
    while (cyc < 288) begin
      step();
      checks++;
      if ({dp_out, out7} !== exp_out(shown, dg(cyc)) || out7 === 7'h79) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, {dp_out, out7}, exp_out(shown, dg(cyc)));
      end
    end
  endtask

  task automatic test_async_reset();
    step(); step();
    din = 32'h55555555; dp_in = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({out7, dp_out, en_out, pending, frame_tick} !== {7'h7F, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got out7=%h dp=%b en=%h pend=%b ft=%b", out7, dp_out, en_out, pending, frame_tick);
    end
    #2 Reset = 1'b1;
    cyc = 0;
    shown = '{32'h0, 8'h0};
    exp_q.delete();
    repeat (64) begin
      step();
      checks++;
      if ({dp_out, out7} !== 8'hC0 || en_out !== ~(8'h01 << dg(cyc))) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%h/%h exp=c0/%h", cyc, {dp_out, out7}, en_out, ~(8'h01 << dg(cyc)));
      end
    end
  endtask

  task automatic test_lzb();
    while (cyc < 70) step();
    din = 32'h000000A0; dp_in = 8'h00; load = 1'b1;
    exp_q.push_back('{din, dp_in});
    step();
    load = 1'b0;
    while (cyc < 128) begin
      step();
      checks++;
      if ({dp_out, out7} !== exp_out(shown, dg(cyc))) begin
        errors++;
        $display("FAIL lzb_frame cyc=%0d got=%h exp=%h", cyc, {dp_out, out7}, exp_out(shown, dg(cyc)));
      end
      if (cyc == 97 || cyc == 101) begin
        checks++;
        if (out7 !== ((cyc == 97) ? 7'h40 : 7'h08)) begin
          errors++; $display("FAIL lzb_low_digit cyc=%0d got=%h exp=%h", cyc, out7, (cyc == 97) ? 7'h40 : 7'h08);
        end
      end
      if (cyc == 105 || cyc == 125) begin
        checks++;
`ifdef SEG7_LZB_EN
        if (out7 !== 7'h7F) begin errors++; $display("FAIL lzb_blank cyc=%0d got=%h exp=7f", cyc, out7); end
`else
        if (out7 !== 7'h40) begin errors++; $display("FAIL lzb_zero cyc=%0d got=%h exp=40", cyc, out7); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_wrap_load();
    test_back_to_back();
    test_async_reset();
    test_lzb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised, time-multiplexed N-digit hex 7-segment driver.
- Successor to the fixed two-4-digit display; it is instantiated by the top-level wrapper beside the processor core.
- Adds a programmable refresh divider, double-buffered (tear-free) value load, per-digit decimal points and a frame-boundary pulse.
- Segment, DP and enable outputs are active-low, matching the board.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..16).
- CLK_DIV, 100000, Clk cycles each digit is held active (>=2).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- load  input  1  capture din/dp_in into the shadow register this cycle.
- din  input  4*N_DIGITS  hex nibbles; digit k = din[4k+3:4k], digit 0 rightmost.
- dp_in  input  N_DIGITS  decimal point per digit, 1 = lit.
- pending  output  1  shadow holds data not yet displayed.
- frame_tick  output  1  one-cycle pulse when the scan wraps.
- out7  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal point, active-low.
- en_out  output  N_DIGITS  digit anodes, active-low, one-hot-low.

Behaviour:
- Registers: prescaler pc (0..CLK_DIV-1), digit index idx (clog2(N_DIGITS) bits, min 1), shadow/disp value+dp registers, pending.
- Reset (Reset=0, asynchronous), all registers cleared:
  - pc=0, idx=0, shadow=0, disp=0, pending=0, frame_tick=0.
  - Outputs off: out7=7'h7F, dp_out=1, en_out all ones.
- Scan:
  - Every cycle pc increments. When pc==CLK_DIV-1 it is a "tick": pc<=0 and idx<=idx+1.
  - On a tick with idx==N_DIGITS-1, idx wraps to 0 (no overflow into unused codes for non-power-of-2 N_DIGITS).
- Outputs are registered from current state every cycle, giving 1-cycle latency after an idx/disp change:
  - en_out <= ~(1<<idx).
  - out7 <= dec(disp[idx]).
  - dp_out <= ~disp_dp[idx].
  - The first cycle after reset release therefore drives digit 0 showing 0.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Load / double buffer:
  - load=1: shadow<=din, shadow_dp<=dp_in, pending<=1.
  - On the wrap tick (idx==N_DIGITS-1 and pc==CLK_DIV-1), if pending: disp<=shadow, pending<=0.
  - The displayed value only changes at frame start, so digits are never torn.
  - frame_tick=1 for exactly the wrap-tick cycle, registered so it appears the following cycle.
- Simultaneous load and wrap tick: disp takes the old shadow, shadow takes the new din, pending stays 1 (new data is shown next frame).
- Repeated loads within a frame: the last one wins; earlier ones are never displayed.
- Reset mid-frame: immediate return to reset state; pending data is discarded.
- N_DIGITS=1: idx fixed at 0; every tick is a wrap tick.

Optional Feature:
- Macro SEG7_LZB_EN (leading-zero blanking).
  - Defined: any digit k>0 such that disp digits k..N_DIGITS-1 are all 0 and dp is clear drives out7=7'h7F and dp_out=1. en_out scanning is unchanged. Digit 0 is never blanked.
  - Undefined: every digit shows its nibble, including leading zeros.

Test Plan:
- Reset, then release, with N_DIGITS=8, CLK_DIV=4:
  - Cycle after release: en_out=8'hFE, out7=7'h40.
  - en_out steps FE->FD->...->7F->FE every 4 cycles.
  - frame_tick pulses once per 32 cycles.
- load with din=32'h0123ABCD, dp_in=8'h01 mid-frame:
  - pending=1 immediately.
  - Display unchanged until wrap, then digit 0 shows out7=7'h21 ('d') with dp_out=0, digit 7 shows 7'h40.
  - pending=0 after the transfer.
- load asserted exactly in the wrap-tick cycle with a prior value pending: old shadow is shown, new value appears one frame later, pending stays 1 across the wrap.
- Two loads (11111111 then 22222222) in one frame: only 2s are ever displayed; 1s never reach out7.
- Reset asserted asynchronously mid-digit (no Clk edge): out7=7'h7F, en_out=8'hFF, pending=0 immediately.
- SEG7_LZB_EN defined, din=32'h000000A0:
  - Digits 7..2 give out7=7'h7F.
  - Digit 1 gives 7'h08, digit 0 gives 7'h40.
  - Undefined build shows 7'h40 on digits 7..2.
